bcd_display_ctrl: RTL and testbench

- Controller that sequences the team's combinational bin2bcd converter (8-bit binary in, 12-bit BCD out) and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Captures an 8-bit value on a load strobe, registers the converted BCD, then time-multiplexes hundreds, tens and ones onto the display with optional leading-zero blanking.
- Sits between switch/arithmetic logic and the board display pins.

---
 rtl/bcd_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Captures an 8-bit value, converts it to BCD through a 3-state sequencer and
// scans hundreds/tens/ones onto a 4-digit common-anode seven-segment display.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin,
  input  logic        load,
  input  logic        lz_en,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_q,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CAPT, LATCH} state_t;

  // Shift-and-add-3 converter; hundreds never exceeds 2 so bits [11:10] stay 0.
  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    logic [19:0] sr;
    sr = {12'd0, b};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
    return sr[19:8];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  state_t      state;
  logic [7:0]  bin_r;
  logic [11:0] conv;

  assign conv = bin2bcd(bin_r);
  assign dp   = 1'b1;

  // Loads arriving outside IDLE are dropped, including the LATCH->IDLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bin_r <= 8'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd_q <= 12'h000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin_r <= bin;
            busy  <= 1'b1;
            state <= CAPT;
          end
        end
        CAPT: state <= LATCH;
        LATCH: begin
          bcd_q <= conv;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic [3:0]    an_sel;
  logic          blank;

  always_comb begin
    digit  = bcd_q[3:0];
    an_sel = 4'b1110;
    blank  = 1'b0;
    case (idx)
      2'd1: begin
        digit  = bcd_q[7:4];
        an_sel = 4'b1101;
        blank  = lz_en && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit  = bcd_q[11:8];
        an_sel = 4'b1011;
        blank  = lz_en && (bcd_q[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  // an/seg are loaded only at the first cycle of a slot, so a bcd_q update
  // mid-slot is held off until the next slot boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1111;
      seg   <= 7'h7F;
    end else begin
      if (presc == LAST) begin
        presc <= '0;
        idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (presc == '0) begin
        an  <= blank ? 4'b1111 : an_sel;
        seg <= blank ? 7'h7F : seg7(digit);
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed and random checks of bcd_display_ctrl against an arithmetic model
// of the conversion and of the digit scan timeline.
module tb_bcd_display_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bin;
  logic        load;
  logic        lz_en;
  logic        busy;
  logic        done;
  logic [11:0] bcd_q;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int edge_cnt;
  int done_cnt = 0;
  bit mon_en = 1'b0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  bcd_display_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .bin(bin), .load(load), .lz_en(lz_en),
    .busy(busy), .done(done), .bcd_q(bcd_q), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mon_en) begin
      chk("an3_off", 16'(an[3]), 16'd1);
      chk("dp_off", 16'(dp), 16'd1);
    end
  end

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic exp_slot(input logic [11:0] b, input logic lz, input int slot,
                          output logic [3:0] a, output logic [6:0] s);
    int h, t, o;
    h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
    if (slot == 0) begin
      a = 4'b1110; s = seg_tbl[o];
    end else if (slot == 1) begin
      if (lz && h == 0 && t == 0) begin a = 4'b1111; s = 7'h7F; end
      else begin a = 4'b1101; s = seg_tbl[t]; end
    end else begin
      if (lz && h == 0) begin a = 4'b1111; s = 7'h7F; end
      else begin a = 4'b1011; s = seg_tbl[h]; end
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    bin  = 8'(v);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy_capt", 16'(busy), 16'd1);
    chk("done_capt", 16'(done), 16'd0);
    @(posedge clk); #1;
    chk("busy_latch", 16'(busy), 16'd1);
    chk("done_latch", 16'(done), 16'd0);
    @(posedge clk); #1;
    chk("busy_end", 16'(busy), 16'd0);
    chk("done_pulse", 16'(done), 16'd1);
    chk("bcd_q", 16'(bcd_q), 16'(model_bcd(v)));
    @(posedge clk); #1;
    chk("done_clear", 16'(done), 16'd0);
  endtask

  task automatic check_display(input logic [11:0] b, input logic lz);
    logic [3:0] ea;
    logic [6:0] es;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      exp_slot(b, lz, ((edge_cnt - 1) / DIV) % 3, ea, es);
      chk("an", 16'(an), 16'(ea));
      chk("seg", 16'(seg), 16'(es));
    end
  endtask

  initial begin
    int start;
    int v;
    rst = 1'b1; load = 1'b0; bin = 8'd0; lz_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_bcd", 16'(bcd_q), 16'h000);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'd1);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_an", 16'(an), 16'b1110);
    chk("first_seg", 16'(seg), 16'(seg_tbl[0]));

    do_load(255);
    check_display(model_bcd(255), 1'b0);

    lz_en = 1'b1;
    do_load(7);
    check_display(model_bcd(7), 1'b1);
    do_load(105);
    check_display(model_bcd(105), 1'b1);
    do_load(0);
    check_display(model_bcd(0), 1'b1);

    // second load lands in CAPT and must be dropped
    @(negedge clk);
    bin = 8'd100; load = 1'b1;
    @(posedge clk); #1;
    start = done_cnt;
    bin = 8'd200;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dbl_bcd", 16'(bcd_q), 16'h100);
    chk("dbl_done_cnt", 16'(done_cnt - start), 16'd1);
    check_display(model_bcd(100), 1'b1);

    // asynchronous reset between edges while busy
    @(negedge clk);
    bin = 8'd150; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("pre_rst_busy", 16'(busy), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 16'(an), 16'hF);
    chk("arst_seg", 16'(seg), 16'h7F);
    chk("arst_bcd", 16'(bcd_q), 16'h000);
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_done", 16'(done), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_an", 16'(an), 16'b1110);
    chk("rel_seg", 16'(seg), 16'(seg_tbl[0]));
    chk("rel_busy", 16'(busy), 16'd0);
    check_display(12'h000, 1'b1);

    lz_en = 1'b0;
    do_load(9);
    check_display(model_bcd(9), 1'b0);

    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 255));
      lz_en = 1'($urandom_range(0, 1));
      do_load(v);
      check_display(model_bcd(v), lz_en);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
